// File: rtl/req_priority_arbiter.sv
// req_priority_arbiter: 8-requester arbiter with a registered one-hot grant.
// Fixed priority (bit 7 highest) or round robin from the last granted index.
// A hold-time limit lets pending requesters preempt a long-running holder.
module req_priority_arbiter #(
    parameter int MAX_HOLD = 16  // legal range 1..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rr_mode,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] grant_id,
    output logic       grant_valid,
    output logic       preempted
);

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // What the arbiter does at the coming edge; drives both next state and outputs.
    typedef enum logic [2:0] {
        ACT_STAY_IDLE,  // IDLE, nothing to grant
        ACT_NEW,        // IDLE -> GRANT, first grant
        ACT_SWITCH,     // holder released, hand over with no idle cycle
        ACT_RELEASE,    // holder released, nobody eligible -> IDLE
        ACT_PREEMPT,    // holder exceeded its hold limit, hand over
        ACT_HOLD        // holder keeps the grant
    } action_t;

    state_t     state;
    state_t     state_nxt;
    action_t    action;

    logic [7:0] hold_cnt;
    logic [2:0] last_id;

    logic [7:0] cand_mask;
    logic       cand_any;
    logic [2:0] win_id;
    logic       holder_req;
    logic       hold_expired;

    logic [7:0] grant_nxt;
    logic [2:0] grant_id_nxt;
    logic       grant_valid_nxt;
    logic       preempted_nxt;
    logic [7:0] hold_cnt_nxt;
    logic [2:0] last_id_nxt;

    // ------------------------------------------------------------------
    // Winner functions
    // ------------------------------------------------------------------

    // Highest set index; the same ordering as the 8:3 priority encoder.
    function automatic logic [2:0] fixed_win(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // First set bit scanning last+1, last+2, ... modulo 8.
    function automatic logic [2:0] rr_win(input logic [7:0] m, input logic [2:0] last);
        logic [2:0] idx;
        logic [2:0] win;
        logic       found;
        win   = 3'd0;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = last + 3'(k);
            if (!found && m[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [7:0] onehot(input logic [2:0] id);
        return 8'b1 << id;
    endfunction

    // ------------------------------------------------------------------
    // Candidate selection
    // ------------------------------------------------------------------

    // Candidates are all requesters from IDLE, everyone but the holder in GRANT.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        cand_mask    = req;
        holder_req   = 1'b0;
        hold_expired = 1'b0;
        if (state == GRANT) begin
            cand_mask    = req & ~grant;
            holder_req   = |(req & grant);
            hold_expired = (hold_cnt >= HOLD_LIMIT);
        end
        cand_any = |cand_mask;
        win_id   = rr_mode ? rr_win(cand_mask, last_id) : fixed_win(cand_mask);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next-state / decision logic
    // ------------------------------------------------------------------

    // Pick the action for this edge and the resulting state.
    always_comb begin
        action    = ACT_STAY_IDLE;
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (en && cand_any) begin
                    action    = ACT_NEW;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!holder_req) begin
                    if (en && cand_any) begin
                        action = ACT_SWITCH;
                    end else begin
                        action    = ACT_RELEASE;
                        state_nxt = IDLE;
                    end
                end else if (en && hold_expired && cand_any) begin
                    action = ACT_PREEMPT;
                end else begin
                    action = ACT_HOLD;
                end
            end
            default: begin
                action    = ACT_RELEASE;
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs)
    // ------------------------------------------------------------------

    // Translate the chosen action into next grant, counters and pulse.
    always_comb begin
        grant_nxt       = grant;
        grant_id_nxt    = grant_id;
        grant_valid_nxt = grant_valid;
        preempted_nxt   = 1'b0;
        hold_cnt_nxt    = hold_cnt;
        last_id_nxt     = last_id;
        unique case (action)
            ACT_NEW, ACT_SWITCH, ACT_PREEMPT: begin
                grant_nxt       = onehot(win_id);
                grant_id_nxt    = win_id;
                grant_valid_nxt = 1'b1;
                preempted_nxt   = (action == ACT_PREEMPT);
                hold_cnt_nxt    = 8'd1;
                last_id_nxt     = win_id;
            end
            ACT_RELEASE, ACT_STAY_IDLE: begin
                grant_nxt       = 8'd0;
                grant_id_nxt    = 3'd0;
                grant_valid_nxt = 1'b0;
                hold_cnt_nxt    = 8'd0;
            end
            ACT_HOLD: begin
                // Saturate so a long single holder never wraps the counter.
                if (hold_cnt < HOLD_LIMIT) hold_cnt_nxt = hold_cnt + 8'd1;
                else                       hold_cnt_nxt = HOLD_LIMIT;
            end
            default: begin
                grant_nxt       = 8'd0;
                grant_id_nxt    = 3'd0;
                grant_valid_nxt = 1'b0;
                hold_cnt_nxt    = 8'd0;
            end
        endcase
    end

    // Output and bookkeeping registers.
    always_ff @(posedge clk) begin
        // NOTE: only control registers exist here, so each one takes an explicit
        // reset value; last_id=7 makes round robin start at requester 0.
        if (rst) begin
            grant       <= 8'd0;
            grant_id    <= 3'd0;
            grant_valid <= 1'b0;
            preempted   <= 1'b0;
            hold_cnt    <= 8'd0;
            last_id     <= 3'd7;
        end else begin
            grant       <= grant_nxt;
            grant_id    <= grant_id_nxt;
            grant_valid <= grant_valid_nxt;
            preempted   <= preempted_nxt;
            hold_cnt    <= hold_cnt_nxt;
            last_id     <= last_id_nxt;
        end
    end

endmodule

// File: tb/tb_req_priority_arbiter.sv
// Directed testbench for req_priority_arbiter: two instances share stimulus,
// one with the default hold limit (16) and one with a hold limit of 4.
module tb_req_priority_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rr_mode;
    logic [7:0] req;

    logic [7:0] grant_a;
    logic [2:0] grant_id_a;
    logic       grant_valid_a;
    logic       preempted_a;

    logic [7:0] grant_b;
    logic [2:0] grant_id_b;
    logic       grant_valid_b;
    logic       preempted_b;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    req_priority_arbiter #(.MAX_HOLD(16)) dut (
        .clk(clk), .rst(rst), .en(en), .rr_mode(rr_mode), .req(req),
        .grant(grant_a), .grant_id(grant_id_a),
        .grant_valid(grant_valid_a), .preempted(preempted_a)
    );

    req_priority_arbiter #(.MAX_HOLD(4)) dut_h4 (
        .clk(clk), .rst(rst), .en(en), .rr_mode(rr_mode), .req(req),
        .grant(grant_b), .grant_id(grant_id_b),
        .grant_valid(grant_valid_b), .preempted(preempted_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one edge, then settle away from it before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare all four outputs of the default instance against expectations.
    task automatic check_a(input string tag, input logic exp_valid, input logic [2:0] exp_id,
                           input logic exp_pre);
        logic [7:0] exp_grant;
        exp_grant = exp_valid ? (8'b1 << exp_id) : 8'd0;
        check({tag, ".grant"}, 32'(grant_a), 32'(exp_grant));
        check({tag, ".id"}, 32'(grant_id_a), exp_valid ? 32'(exp_id) : 32'd0);
        check({tag, ".valid"}, 32'(grant_valid_a), 32'(exp_valid));
        check({tag, ".pre"}, 32'(preempted_a), 32'(exp_pre));
    endtask

    task automatic check_b(input string tag, input logic exp_valid, input logic [2:0] exp_id,
                           input logic exp_pre);
        logic [7:0] exp_grant;
        exp_grant = exp_valid ? (8'b1 << exp_id) : 8'd0;
        check({tag, ".grant"}, 32'(grant_b), 32'(exp_grant));
        check({tag, ".id"}, 32'(grant_id_b), exp_valid ? 32'(exp_id) : 32'd0);
        check({tag, ".valid"}, 32'(grant_valid_b), 32'(exp_valid));
        check({tag, ".pre"}, 32'(preempted_b), 32'(exp_pre));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b0;
        rr_mode = 1'b0;
        req     = 8'd0;

        // Reset state.
        do_reset();
        check_a("reset_a", 1'b0, 3'd0, 1'b0);
        check_b("reset_b", 1'b0, 3'd0, 1'b0);

        // 1. Fixed priority, back-to-back handover, then idle.
        en  = 1'b1;
        req = 8'b0010_0110;
        tick();
        check_a("t1_first", 1'b1, 3'd5, 1'b0);
        req = 8'b0000_0110;
        tick();
        check_a("t1_handover", 1'b1, 3'd2, 1'b0);
        req = 8'd0;
        tick();
        check_a("t1_idle", 1'b0, 3'd0, 1'b0);

        // 2. Round robin from reset with every holder releasing after one cycle.
        do_reset();
        rr_mode = 1'b1;
        req     = 8'hFF;
        tick();
        check_a("t2_rr0", 1'b1, 3'd0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            req = 8'hFF & ~(8'b1 << ((i - 1) % 8));
            tick();
            check_a($sformatf("t2_rr%0d", i), 1'b1, 3'(i % 8), 1'b0);
        end

        // 3. Fixed priority with hold limit 4: 7 and 1 alternate by preemption.
        do_reset();
        rr_mode = 1'b0;
        req     = 8'b1000_0010;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_b($sformatf("t3_hold7_%0d", i), 1'b1, 3'd7, 1'b0);
        end
        tick();
        check_b("t3_pre_to1", 1'b1, 3'd1, 1'b1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check_b($sformatf("t3_hold1_%0d", i), 1'b1, 3'd1, 1'b0);
        end
        tick();
        check_b("t3_pre_to7", 1'b1, 3'd7, 1'b1);
        check_a("t3_long_hold", 1'b1, 3'd7, 1'b0);
        tick();
        check_b("t3_pulse_end", 1'b1, 3'd7, 1'b0);

        // 4. Enable gating: no grant while en=0, release goes idle with en=0.
        do_reset();
        en  = 1'b0;
        req = 8'h18;
        tick();
        tick();
        check_a("t4_en0_idle", 1'b0, 3'd0, 1'b0);
        en = 1'b1;
        tick();
        check_a("t4_en1_grant", 1'b1, 3'd4, 1'b0);
        en = 1'b0;
        tick();
        check_a("t4_en0_keep", 1'b1, 3'd4, 1'b0);
        req = 8'h08;
        tick();
        check_a("t4_release_idle", 1'b0, 3'd0, 1'b0);
        tick();
        check_a("t4_still_idle", 1'b0, 3'd0, 1'b0);
        en = 1'b1;
        tick();
        check_a("t4_regrant", 1'b1, 3'd3, 1'b0);

        // 5. Mode change leaves the holder alone; reset mid-grant restores last_id.
        rr_mode = 1'b1;
        req     = 8'hFF;
        tick();
        check_a("t5_mode_keep", 1'b1, 3'd3, 1'b0);
        rst = 1'b1;
        tick();
        check_a("t5_rst_a", 1'b0, 3'd0, 1'b0);
        check_b("t5_rst_b", 1'b0, 3'd0, 1'b0);
        rst = 1'b0;
        tick();
        check_a("t5_rr_first", 1'b1, 3'd0, 1'b0);

        // 6. Single long holder never preempts; saturated count preempts on en rise.
        do_reset();
        rr_mode = 1'b0;
        en      = 1'b1;
        req     = 8'h08;
        for (int i = 1; i <= 40; i++) begin
            tick();
            check_a($sformatf("t6_single_%0d", i), 1'b1, 3'd3, 1'b0);
        end
        en  = 1'b0;
        req = 8'h88;
        tick();
        check_a("t6_en0_nopre", 1'b1, 3'd3, 1'b0);
        en = 1'b1;
        tick();
        check_a("t6_en_rise_pre", 1'b1, 3'd7, 1'b1);
        tick();
        check_a("t6_pulse_end", 1'b1, 3'd7, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
